// File: rtl/stash_pkg.sv
// Shared helpers for the sample stash: width derivation, ring-pointer arithmetic
// and the navigation command encoding used by the browse priority decoder.
package stash_pkg;

    typedef enum logic [1:0] {
        NAV_NONE,
        NAV_NEXT,
        NAV_PREV,
        NAV_LATEST
    } nav_cmd_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int mod_inc(input int v, input int depth);
        return (v == depth - 1) ? 0 : v + 1;
    endfunction

    function automatic int mod_dec(input int v, input int depth);
        return (v == 0) ? depth - 1 : v - 1;
    endfunction

    // Address of the entry 'age' writes back from the newest; DEPTH need not be a power of two.
    function automatic int ring_addr(input int wp, input int age, input int depth);
        int a;
        a = mod_dec(wp, depth) - age;
        return (a < 0) ? a + depth : a;
    endfunction

endpackage

// File: rtl/stash_nav_if.sv
// Sample/browse bus between the lap-capture source, the stash and the display path.
interface stash_nav_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    localparam int AW = stash_pkg::clog2(DEPTH);

    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic             prev_sample;
    logic             jump_latest;
    logic             clear;
    logic [WIDTH-1:0] sample_out;
    logic [AW-1:0]    read_idx;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overwrite;

    modport master (
        output sample_in, sample_in_valid, next_sample, prev_sample, jump_latest, clear,
        input  sample_out, read_idx, count, empty, full, overwrite
    );

    modport slave (
        input  sample_in, sample_in_valid, next_sample, prev_sample, jump_latest, clear,
        output sample_out, read_idx, count, empty, full, overwrite
    );
endinterface

// File: rtl/stash_ring_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module stash_ring_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stash_nav.sv
// Ring buffer of the last DEPTH samples with next/prev browsing, jump-to-latest,
// clear, occupancy and overwrite status; sample_out bypasses the live input on writes.
module stash_nav
    import stash_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input logic       clk,
    input logic       reset,
    stash_nav_if.slave bus
);
    localparam int          AW      = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]    wp;
    logic [AW-1:0]    age;
    logic [AW:0]      count;
    logic             overwrite;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             we;
    nav_cmd_e         nav;

    // Write is blocked by clear (higher priority) and by reset.
    assign we      = bus.sample_in_valid & ~bus.clear & reset;
    assign rd_addr = AW'(ring_addr(32'(wp), 32'(age), DEPTH));

    stash_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (bus.sample_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        nav = NAV_NONE;
        if (bus.jump_latest)                         nav = NAV_LATEST;
        else if (bus.next_sample && !bus.prev_sample) nav = NAV_NEXT;
        else if (bus.prev_sample && !bus.next_sample) nav = NAV_PREV;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp        <= '0;
            age       <= '0;
            count     <= '0;
            overwrite <= 1'b0;
        end else begin
            overwrite <= 1'b0;
            if (bus.clear) begin
                wp    <= '0;
                age   <= '0;
                count <= '0;
            end else if (bus.sample_in_valid) begin
                wp        <= AW'(mod_inc(32'(wp), DEPTH));
                age       <= '0;
                count     <= (count == DEPTH_C) ? count : count + (AW+1)'(1);
                overwrite <= (count == DEPTH_C);
            end else if (count != '0) begin
                case (nav)
                    NAV_LATEST: age <= '0;
                    NAV_NEXT:   age <= ({1'b0, age} == count - (AW+1)'(1)) ? '0 : age + AW'(1);
                    NAV_PREV:   age <= (age == '0) ? AW'(count - (AW+1)'(1)) : age - AW'(1);
                    default:    age <= age;
                endcase
            end
        end
    end

    always_comb begin
        if (bus.sample_in_valid) bus.sample_out = bus.sample_in;
        else if (count != '0)    bus.sample_out = rd_data;
        else                     bus.sample_out = '0;
    end

    assign bus.read_idx  = age;
    assign bus.count     = count;
    assign bus.empty     = (count == '0);
    assign bus.full      = (count == DEPTH_C);
    assign bus.overwrite = overwrite;
endmodule

// File: tb/tb_stash_nav.sv
// Directed bench for stash_nav (WIDTH=8, DEPTH=5) with hand-computed expectations.
module tb_stash_nav;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    stash_nav_if #(.WIDTH(8), .DEPTH(5)) bus ();

    stash_nav #(.WIDTH(8), .DEPTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;
        bus.next_sample     = 1'b0;
        bus.prev_sample     = 1'b0;
        bus.jump_latest     = 1'b0;
        bus.clear           = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.sample_out !== 8'd0) begin n_err++; $display("FAIL rst_sample_out got %0d want 0", bus.sample_out); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", bus.full); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.read_idx !== 3'd0) begin n_err++; $display("FAIL rst_read_idx got %0d want 0", bus.read_idx); end
        n_cmp++; if (bus.overwrite !== 1'b0) begin n_err++; $display("FAIL rst_overwrite got %b want 0", bus.overwrite); end
    endtask

    task automatic test_write_browse();
        logic [7:0] exp_next [3];
        exp_next = '{8'd11, 8'd10, 8'd12};
        for (int v = 10; v <= 12; v++) begin
            bus.sample_in       = 8'(v);
            bus.sample_in_valid = 1'b1;
            #1;
            n_cmp++; if (bus.sample_out !== 8'(v)) begin n_err++; $display("FAIL bypass got %0d want %0d", bus.sample_out, v); end
            tick();
        end
        bus.sample_in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.sample_out !== 8'd12) begin n_err++; $display("FAIL wb_latest got %0d want 12", bus.sample_out); end
        n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL wb_count got %0d want 3", bus.count); end
        n_cmp++; if (bus.read_idx !== 3'd0) begin n_err++; $display("FAIL wb_read_idx got %0d want 0", bus.read_idx); end
        bus.next_sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.sample_out !== exp_next[i]) begin n_err++; $display("FAIL wb_next%0d got %0d want %0d", i, bus.sample_out, exp_next[i]); end
        end
        bus.next_sample = 1'b0;
        bus.prev_sample = 1'b1;
        tick();
        bus.prev_sample = 1'b0;
        n_cmp++; if (bus.sample_out !== 8'd10) begin n_err++; $display("FAIL wb_prev got %0d want 10", bus.sample_out); end
        n_cmp++; if (bus.read_idx !== 3'd2) begin n_err++; $display("FAIL wb_prev_idx got %0d want 2", bus.read_idx); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_next [5];
        exp_next = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd6};
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int v = 0; v <= 6; v++) begin
            bus.sample_in       = 8'(v);
            bus.sample_in_valid = 1'b1;
            tick();
            n_cmp++; if (bus.overwrite !== (v >= 5)) begin n_err++; $display("FAIL wrap_ovw%0d got %b want %b", v, bus.overwrite, (v >= 5)); end
        end
        bus.sample_in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 4'd5) begin n_err++; $display("FAIL wrap_count got %0d want 5", bus.count); end
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL wrap_full got %b want 1", bus.full); end
        n_cmp++; if (bus.sample_out !== 8'd6) begin n_err++; $display("FAIL wrap_latest got %0d want 6", bus.sample_out); end
        bus.next_sample = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.sample_out !== exp_next[i]) begin n_err++; $display("FAIL wrap_next%0d got %0d want %0d", i, bus.sample_out, exp_next[i]); end
        end
        bus.next_sample = 1'b0;
        n_cmp++; if (bus.overwrite !== 1'b0) begin n_err++; $display("FAIL wrap_ovw_idle got %b want 0", bus.overwrite); end
        bus.prev_sample = 1'b1;
        tick();
        bus.prev_sample = 1'b0;
        n_cmp++; if (bus.sample_out !== 8'd2) begin n_err++; $display("FAIL wrap_prev got %0d want 2", bus.sample_out); end
        n_cmp++; if (bus.read_idx !== 3'd4) begin n_err++; $display("FAIL wrap_prev_idx got %0d want 4", bus.read_idx); end
    endtask

    task automatic test_conflict();
        bus.next_sample = 1'b1;
        bus.prev_sample = 1'b1;
        tick();
        bus.prev_sample = 1'b0;
        n_cmp++; if (bus.read_idx !== 3'd4) begin n_err++; $display("FAIL both_idx got %0d want 4", bus.read_idx); end
        n_cmp++; if (bus.sample_out !== 8'd2) begin n_err++; $display("FAIL both_out got %0d want 2", bus.sample_out); end
        bus.sample_in       = 8'd9;
        bus.sample_in_valid = 1'b1;
        tick();
        bus.sample_in_valid = 1'b0;
        bus.next_sample     = 1'b0;
        #1;
        n_cmp++; if (bus.read_idx !== 3'd0) begin n_err++; $display("FAIL wrnav_idx got %0d want 0", bus.read_idx); end
        n_cmp++; if (bus.sample_out !== 8'd9) begin n_err++; $display("FAIL wrnav_out got %0d want 9", bus.sample_out); end
        n_cmp++; if (bus.overwrite !== 1'b1) begin n_err++; $display("FAIL wrnav_ovw got %b want 1", bus.overwrite); end
        bus.next_sample = 1'b1;
        repeat (3) tick();
        bus.next_sample = 1'b0;
        n_cmp++; if (bus.read_idx !== 3'd3) begin n_err++; $display("FAIL pre_jump_idx got %0d want 3", bus.read_idx); end
        bus.jump_latest = 1'b1;
        tick();
        bus.jump_latest = 1'b0;
        n_cmp++; if (bus.read_idx !== 3'd0) begin n_err++; $display("FAIL jump_idx got %0d want 0", bus.read_idx); end
        n_cmp++; if (bus.sample_out !== 8'd9) begin n_err++; $display("FAIL jump_out got %0d want 9", bus.sample_out); end
    endtask

    task automatic test_clear();
        bus.next_sample = 1'b1;
        repeat (2) tick();
        bus.next_sample = 1'b0;
        n_cmp++; if (bus.read_idx !== 3'd2) begin n_err++; $display("FAIL clr_pre_idx got %0d want 2", bus.read_idx); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL clr_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.sample_out !== 8'd0) begin n_err++; $display("FAIL clr_out got %0d want 0", bus.sample_out); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", bus.count); end
        bus.next_sample = 1'b1;
        tick();
        bus.next_sample = 1'b0;
        n_cmp++; if (bus.read_idx !== 3'd0) begin n_err++; $display("FAIL clr_nav_idx got %0d want 0", bus.read_idx); end
        bus.sample_in       = 8'd7;
        bus.sample_in_valid = 1'b1;
        tick();
        bus.sample_in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.sample_out !== 8'd7) begin n_err++; $display("FAIL clr_wr_out got %0d want 7", bus.sample_out); end
        n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL clr_wr_count got %0d want 1", bus.count); end
    endtask

    task automatic test_reset_mid();
        bus.sample_in       = 8'd20;
        bus.sample_in_valid = 1'b1;
        tick();
        bus.sample_in = 8'd21;
        #3;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 4'd2) begin n_err++; $display("FAIL midrst_count got %0d want 2", bus.count); end
        n_cmp++; if (bus.sample_out !== 8'd21) begin n_err++; $display("FAIL midrst_out got %0d want 21", bus.sample_out); end
        tick();
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_edge_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_edge_empty got %b want 1", bus.empty); end
        bus.sample_in = 8'd22;
        tick();
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_hold_count got %0d want 0", bus.count); end
        reset               = 1'b1;
        bus.sample_in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_rel_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.sample_out !== 8'd0) begin n_err++; $display("FAIL rst_rel_out got %0d want 0", bus.sample_out); end
        n_cmp++; if (bus.overwrite !== 1'b0) begin n_err++; $display("FAIL rst_rel_ovw got %b want 0", bus.overwrite); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        test_reset();
        test_write_browse();
        test_wrap();
        test_conflict();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stash_nav.md
Name: stash_nav

Overview:
- Parametrised successor to the lab's single-depth sample stash: a ring buffer of the last DEPTH samples of WIDTH bits.
- Adds bidirectional browsing (next/prev), jump-to-latest, clear, occupancy count, and full/empty/overwrite status.
- Sits between the sample source (stopwatch lap capture) and the display path.
- sample_out always shows either the live input (bypass) or the currently browsed stored entry.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 5, number of stored entries; legal range 2..256.
- AW, $clog2(DEPTH), address and age width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-low reset.
- sample_in  in  WIDTH  data to store.
- sample_in_valid  in  1  write strobe: one entry per cycle while high.
- next_sample  in  1  browse one entry older (wraps).
- prev_sample  in  1  browse one entry newer (wraps).
- jump_latest  in  1  return browse position to newest entry.
- clear  in  1  synchronous empty of the buffer.
- sample_out  out  WIDTH  bypass or browsed entry.
- read_idx  out  AW  age of browsed entry (0 = newest).
- count  out  AW+1  stored entries, saturates at DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overwrite  out  1  one-cycle pulse when a write displaced the oldest entry.

Behaviour:
- Reset (reset==0 at a clk edge) dominates all inputs: wp=0, age=0, count=0, overwrite=0. Memory contents are don't-care.
- Low reset between edges has no effect until the next edge.
- State: wp (next write address), age (0..count-1), count. Browsed address = (wp-1-age) mod DEPTH, computed without a power-of-2 assumption.
- Per-edge priority (highest first):
  - clear: count=0, age=0, wp=0.
  - write (sample_in_valid): mem[wp]=sample_in; wp=(wp+1) mod DEPTH; count=min(count+1,DEPTH); age=0. Navigation inputs in the same cycle are ignored.
  - jump_latest: age=0.
  - next_sample and prev_sample both high: no move.
  - next_sample: age = (age==count-1) ? 0 : age+1.
  - prev_sample: age = (age==0) ? count-1 : age-1.
- Navigation is ignored while empty.
- next/prev are level-sensitive: one step per cycle while held.
- overwrite is registered; it is 1 in the cycle after a write that occurs while full (or while count==DEPTH before that write), and 0 otherwise. clear and reset force it to 0.
- sample_out (combinational):
  - = sample_in while sample_in_valid (zero-latency bypass).
  - otherwise = mem[browsed address] if !empty.
  - otherwise = 0.
- Memory read is asynchronous, so the browsed value is valid in the same cycle the pointer updates.
- read_idx = age. empty, full and count are derived from registered count (no combinational path from inputs).
- Wrap-around: after more than DEPTH writes, the oldest entries are silently replaced. Ages always refer to the DEPTH most recent writes.

Decomposition:
- Shared package/header stash_pkg: AW derivation function (clog2), mod-DEPTH increment/decrement helpers, and a navigation-command encoding (NAV_NONE, NAV_NEXT, NAV_PREV, NAV_LATEST) used by the priority decoder.
- One sub-module, stash_ring_mem: DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
- Pointer, age and count logic stays in stash_nav.

Test Plan:
- Reset, then idle 3 cycles -> sample_out=0, empty=1, full=0, count=0, read_idx=0, overwrite=0.
- Write 10, 11, 12 on consecutive cycles -> sample_out equals sample_in 1 ns after each strobe. Afterwards sample_out=12, count=3, read_idx=0. Then next x3 -> 11, 10, 12 (wrap). Then prev x1 -> 10.
- Write 0..6 (DEPTH=5):
  - overwrite pulses exactly after the writes of 5 and 6.
  - Then count=5, full=1, sample_out=6.
  - next x5 -> 5, 4, 3, 2, 6.
  - prev from age 0 -> 2 with read_idx=4.
- Conflict cases:
  - next and prev together -> no move.
  - Write 9 while next=1 -> age=0, sample_out=9.
  - jump_latest from age 3 -> age 0.
- Browse to age 2, then clear=1 -> next cycle empty=1, sample_out=0. next_sample ignored (read_idx=0). Write 7 -> sample_out=7, count=1.
- Drive reset low mid-cycle during a write burst -> outputs unchanged until the next rising edge, then the reset values. Writes during reset are not stored (count=0 after release).
